// File: rtl/reset_sequencer.sv
// Staged reset release: hold all outputs in reset until lock has been stable,
// then release them one at a time, lowest bit first.
module reset_sequencer #(
    parameter int unsigned STRETCH_CYC = 16,
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned NUM_OUT     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock,
    input  logic               req,
    output logic [NUM_OUT-1:0] rst_out_N,
    output logic               busy,
    output logic               done
);

    localparam int unsigned MAX_CYC = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [NUM_OUT-1:0] r_rst_n, w_rst_n_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_abort;

    assign w_abort = !lock || req;

    // NOTE: every comb output gets a default first so no path leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_HOLD: begin
                w_rst_n_nxt = '0;
                w_busy_nxt  = 1'b1;
                w_idx_nxt   = '0;
                if (w_abort) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == STRETCH_LAST) begin
                    w_cnt_nxt      = '0;
                    w_idx_nxt      = IDX_W'(1);
                    w_rst_n_nxt[0] = 1'b1;
                    if (NUM_OUT == 1) begin
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (w_abort) begin
                    w_state_nxt = ST_HOLD;
                    w_rst_n_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    // Thermometer fill keeps the release order monotonic by construction.
                    for (int k = 0; k < int'(NUM_OUT); k++) begin
                        w_rst_n_nxt[k] = (k <= int'(r_idx));
                    end
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                w_rst_n_nxt = '1;
                w_busy_nxt  = 1'b0;
                if (w_abort) begin
                    w_state_nxt = ST_HOLD;
                    w_rst_n_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_HOLD;
                w_rst_n_nxt = '0;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign rst_out_N = r_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a default 3-output instance driven from a
// vector table, plus a 1-output / 1-cycle-stretch instance checked by hand.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       req = 1'b0;
    logic [2:0] rst_out_N;
    logic       busy, done;
    logic [0:0] rst_out1_N;
    logic       busy1, done1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk(clk), .rst(rst), .lock(lock), .req(req),
        .rst_out_N(rst_out_N), .busy(busy), .done(done)
    );

    reset_sequencer #(.STRETCH_CYC(1), .GAP_CYC(8), .NUM_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .lock(lock), .req(req),
        .rst_out_N(rst_out1_N), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic       rst;
        logic       lock;
        logic       req;
        int         n;
        logic [2:0] exp_out;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic q, input int n,
                       input logic [2:0] o, input logic b, input logic d);
        vec_t v;
        v = '{rst: r, lock: l, req: q, n: n, exp_out: o, exp_busy: b, exp_done: d};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic l, input logic q, input int n);
        rst = r; lock = l; req = q;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Independent invariants sampled on the falling edge: monotonic release and busy.
    always @(negedge clk) begin
        if (mon_en) begin
            logic mono_ok;
            mono_ok = 1'b1;
            for (int k = 1; k < 3; k++)
                for (int j = 0; j < k; j++)
                    if (rst_out_N[k] && !rst_out_N[j]) mono_ok = 1'b0;
            check("monotonic", {31'd0, mono_ok}, 32'd1);
            check("busy_vs_out", {31'd0, busy}, {31'd0, rst_out_N != 3'b111});
        end
    end

    initial begin
        // Hand sequence: NUM_OUT=1, STRETCH_CYC=1 instance.
        drive(1'b1, 1'b1, 1'b0, 1);
        mon_en = 1'b1;
        check("n1_reset_out",  {31'd0, rst_out1_N}, 32'd0);
        check("n1_reset_busy", {31'd0, busy1}, 32'd1);
        check("n1_reset_done", {31'd0, done1}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1);
        check("n1_e1_out",  {31'd0, rst_out1_N}, 32'd1);
        check("n1_e1_busy", {31'd0, busy1}, 32'd0);
        check("n1_e1_done", {31'd0, done1}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1);
        check("n1_e2_done", {31'd0, done1}, 32'd0);
        check("n1_e2_out",  {31'd0, rst_out1_N}, 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1);
        check("n1_req_out",  {31'd0, rst_out1_N}, 32'd0);
        check("n1_req_busy", {31'd0, busy1}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1);
        check("n1_rerun_out",  {31'd0, rst_out1_N}, 32'd1);
        check("n1_rerun_done", {31'd0, done1}, 32'd1);

        // Basic sequence from reset: E0 reset, bits at E16/E24/E32.
        add(1, 1, 0,  1, 3'b000, 1, 0);
        add(0, 1, 0, 15, 3'b000, 1, 0);
        add(0, 1, 0,  1, 3'b001, 1, 0);
        add(0, 1, 0,  7, 3'b001, 1, 0);
        add(0, 1, 0,  1, 3'b011, 1, 0);
        add(0, 1, 0,  7, 3'b011, 1, 0);
        add(0, 1, 0,  1, 3'b111, 0, 1);
        add(0, 1, 0,  1, 3'b111, 0, 0);
        add(0, 1, 0,  5, 3'b111, 0, 0);
        // Soft request in RUN: restart and full sequence again.
        add(0, 1, 1,  1, 3'b000, 1, 0);
        add(0, 1, 0, 15, 3'b000, 1, 0);
        add(0, 1, 0,  1, 3'b001, 1, 0);
        add(0, 1, 0, 15, 3'b011, 1, 0);
        add(0, 1, 0,  1, 3'b111, 0, 1);
        add(0, 1, 0,  1, 3'b111, 0, 0);
        // Lock lost at E28 between bit-1 and bit-2 releases, held low, then returns.
        add(1, 1, 0,  1, 3'b000, 1, 0);
        add(0, 1, 0, 24, 3'b011, 1, 0);
        add(0, 1, 0,  3, 3'b011, 1, 0);
        add(0, 0, 0,  1, 3'b000, 1, 0);
        add(0, 0, 0,  5, 3'b000, 1, 0);
        add(0, 1, 0, 15, 3'b000, 1, 0);
        add(0, 1, 0,  1, 3'b001, 1, 0);
        add(0, 1, 0, 15, 3'b011, 1, 0);
        add(0, 1, 0,  1, 3'b111, 0, 1);
        // One-cycle lock drop at E10 restarts the stretch count.
        add(1, 1, 0,  1, 3'b000, 1, 0);
        add(0, 1, 0,  9, 3'b000, 1, 0);
        add(0, 0, 0,  1, 3'b000, 1, 0);
        add(0, 1, 0, 15, 3'b000, 1, 0);
        add(0, 1, 0,  1, 3'b001, 1, 0);
        add(0, 1, 0, 15, 3'b011, 1, 0);
        add(0, 1, 0,  1, 3'b111, 0, 1);
        // rst reasserted at E20 in RELEASE.
        add(1, 1, 0,  1, 3'b000, 1, 0);
        add(0, 1, 0, 19, 3'b001, 1, 0);
        add(1, 1, 0,  1, 3'b000, 1, 0);
        add(0, 1, 0, 16, 3'b001, 1, 0);
        // req and lock=0 together, then continuous req, then clean release.
        add(0, 0, 1,  3, 3'b000, 1, 0);
        add(0, 1, 1, 20, 3'b000, 1, 0);
        add(0, 1, 0, 15, 3'b000, 1, 0);
        add(0, 1, 0,  1, 3'b001, 1, 0);
        add(0, 1, 0, 16, 3'b111, 0, 1);
        // rst in RUN overrides lock/req and holds for as long as asserted.
        add(1, 1, 0,  1, 3'b000, 1, 0);
        add(1, 1, 0, 20, 3'b000, 1, 0);
        add(0, 1, 0, 16, 3'b001, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].lock, vecs[i].req, vecs[i].n);
            check($sformatf("vec%0d_out", i),  {29'd0, rst_out_N}, {29'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_busy", i), {31'd0, busy},      {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_done", i), {31'd0, done},      {31'd0, vecs[i].exp_done});
        end

        // done must stay a single-cycle pulse: watch a full release window.
        begin
            int pulses;
            pulses = 0;
            drive(1'b1, 1'b1, 1'b0, 1);
            for (int c = 0; c < 40; c++) begin
                drive(1'b0, 1'b1, 1'b0, 1);
                if (done === 1'b1) pulses++;
            end
            check("done_pulse_count", pulses, 32'd1);
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STRETCH_CYC, default 16: consecutive lock-high cycles with all outputs held in reset before the first release; legal range 1..65535.
REQ-002 SHALL have parameter GAP_CYC, default 8: cycles between successive output releases; legal range 1..65535.
REQ-003 SHALL have parameter NUM_OUT, default 3: number of sequenced reset outputs; legal range 1..8.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port lock, input, 1: clock-source-stable indication, already synchronous to clk.
REQ-007 SHALL have port req, input, 1: soft-reset request, sampled every cycle, level or pulse.
REQ-008 SHALL have port rst_out_N, output, NUM_OUT: active-low reset outputs, bit 0 released first.
REQ-009 SHALL have port busy, output, 1: high whenever any rst_out_N bit is low.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when the sequence completes.

Function
REQ-011 SHALL implement states HOLD, RELEASE and RUN, with registered outputs only.
REQ-012 HOLD behaviour: rst_out_N all 0 and busy=1; counter increments on each edge with lock=1 and req=0, and clears to 0 on any edge with lock=0 or req=1.
REQ-013 HOLD exit: on the edge where the counter equals STRETCH_CYC-1 and lock=1 and req=0, SHALL go to RELEASE, set rst_out_N[0]=1, clear the counter and set index=1.
REQ-014 RELEASE behaviour: counter increments each edge; when it equals GAP_CYC-1, SHALL set rst_out_N[index]=1, increment index and clear the counter.
REQ-015 RELEASE exit: the edge that releases bit NUM_OUT-1 SHALL also enter RUN, set busy=0 and set done=1.
REQ-016 NUM_OUT=1: the HOLD exit edge SHALL go directly to RUN, with busy=0 and done=1 on that edge.
REQ-017 done SHALL be high for exactly one cycle per completed sequence and low otherwise.
REQ-018 RUN behaviour: rst_out_N all 1 and busy=0; state held while lock=1 and req=0.
REQ-019 Abort: lock=0 or req=1 sampled in RELEASE or RUN SHALL, on that edge, go to HOLD, drive rst_out_N all 0, set busy=1, clear counter and index, and force done=0.
REQ-020 Simultaneous events: req=1 with lock=0 SHALL behave identically to either alone; a continuous req=1 or lock=0 SHALL hold the block in HOLD indefinitely.
REQ-021 Monotonic release: rst_out_N[k] SHALL never be 1 while rst_out_N[j]=0 for any j<k.
REQ-022 Counter width SHALL be clog2(max(STRETCH_CYC,GAP_CYC)+1) bits, and the counter SHALL never wrap.
REQ-023 Index width SHALL be clog2(NUM_OUT+1) bits, and the index SHALL never exceed NUM_OUT.

Reset
REQ-024 rst=1 at an edge SHALL force HOLD with counter=0, index=0, rst_out_N all 0, busy=1 and done=0, overriding req and lock.
REQ-025 rst asserted mid-RELEASE or in RUN SHALL take effect on the same edge, with no partial release retained.
REQ-026 After rst deasserts, sequencing SHALL start from zero; the first counted edge is the first edge with rst=0.

Verification
REQ-027 Defaults; rst high through edge E0; lock=1 and req=0 from then -> rst_out_N: 000 through E15, 001 at E16, 011 at E24, 111 at E32; busy falls at E32; done=1 only in the cycle after E32.
REQ-028 Same as REQ-027 but lock=0 for one cycle sampled at E10 -> counter restarts; bit 0 rises at E26 and done follows E42.
REQ-029 In RUN, req=1 sampled at edge Ex for one cycle -> rst_out_N=000 and busy=1 at Ex; bit 0 rises at Ex+16 and done follows Ex+32.
REQ-030 lock drops at E28, between the bit-1 and bit-2 releases -> rst_out_N=000 at E28 with no done pulse; the full sequence restarts after lock returns.
REQ-031 NUM_OUT=1, STRETCH_CYC=1 -> rst_out_N=1 and done pulses at the first edge after rst deasserts, i.e. E1.
REQ-032 rst reasserted at E20, in RELEASE -> all outputs 0, busy=1 and done=0 at E20; the monotonic-release check passes throughout every scenario.
